// File: rtl/expr_seq_eval_if.sv
// Operand/result handshake bundle for expr_seq_eval.
// The master drives operands and accepts results; the slave is the evaluator.
interface expr_seq_eval_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic [WIDTH-1:0] in_d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_tmp;
  logic [WIDTH-1:0] out_q1;
  logic [WIDTH-1:0] out_q2;
  logic [1:0]       div0;

  modport master (
    output in_valid, in_a, in_b, in_c, in_d, out_ready,
    input  in_ready, out_valid, out_tmp, out_q1, out_q2, div0
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, out_ready,
    output in_ready, out_valid, out_tmp, out_q1, out_q2, div0
  );
endinterface

// File: rtl/expr_seq_eval.sv
// Sequential evaluator of (a<<c)+b, b/c+b and (a+b+c*d)/((a<<c)+b)+b using one
// shared restoring divider that retires one quotient bit per clock.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand set
// DIV1  | dividing b by c
// DIV2  | dividing sum by tmp
// DONE  | results held until the consumer takes them
module expr_seq_eval #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  expr_seq_eval_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DIV1, DIV2, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] b_r, tmp_r, sum_r, q1_r;
  logic [WIDTH-1:0] quo, rem, dvs;
  logic             neg, dz, c_zero;

  logic [WIDTH-1:0] shl_c, tmp_c, sum_c;
  logic [WIDTH:0]   rem_sh, diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx, quo_nx, q_res;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  always_comb begin
    shl_c  = (bus.in_c >= WIDTH'(WIDTH)) ? '0 : (bus.in_a << bus.in_c);
    tmp_c  = shl_c + bus.in_b;
    sum_c  = bus.in_a + bus.in_b + bus.in_c * bus.in_d;
    // quo doubles as the dividend shift register; quotient bits enter at the LSB
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    qbit   = ~diff[WIDTH];
    rem_nx = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], qbit};
    q_res  = dz ? '1 : (neg ? -quo_nx : quo_nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      b_r           <= '0;
      tmp_r         <= '0;
      sum_r         <= '0;
      q1_r          <= '0;
      quo           <= '0;
      rem           <= '0;
      dvs           <= '0;
      neg           <= 1'b0;
      dz            <= 1'b0;
      c_zero        <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_tmp   <= '0;
      bus.out_q1    <= '0;
      bus.out_q2    <= '0;
      bus.div0      <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            b_r          <= bus.in_b;
            tmp_r        <= tmp_c;
            sum_r        <= sum_c;
            quo          <= mag(bus.in_b);
            rem          <= '0;
            dvs          <= mag(bus.in_c);
            neg          <= bus.in_b[WIDTH-1] ^ bus.in_c[WIDTH-1];
            dz           <= (bus.in_c == '0);
            c_zero       <= (bus.in_c == '0);
            cnt          <= CNT_MAX;
            bus.in_ready <= 1'b0;
            state        <= DIV1;
          end
        end
        DIV1: begin
          quo <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            q1_r  <= q_res + b_r;
            quo   <= mag(sum_r);
            rem   <= '0;
            dvs   <= mag(tmp_r);
            neg   <= sum_r[WIDTH-1] ^ tmp_r[WIDTH-1];
            dz    <= (tmp_r == '0);
            cnt   <= CNT_MAX;
            state <= DIV2;
          end
        end
        DIV2: begin
          quo <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            bus.out_tmp   <= tmp_r;
            bus.out_q1    <= q1_r;
            bus.out_q2    <= q_res + b_r;
            bus.div0      <= {dz, c_zero};
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/expr_seq_eval.md
Name: expr_seq_eval

Overview:
- Parametrised, sequential successor to the team's combinational shift/add/mul/div expression test design.
- Evaluates three fixed signed expressions over four operands: (a<<c)+b, b/c+b, and (a+b+c*d)/((a<<c)+b)+b.
- Uses one shared iterative restoring divider (one quotient bit per cycle) behind valid/ready handshakes.
- Serves as the multi-cycle arithmetic test design for the synthesis flow (FSM + counter + handshake).

Parameters:
- WIDTH, 32, operand/result width in bits (two's complement).
- CNT_W, $clog2(WIDTH), width of the divider iteration counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  signed operand a.
- in_b  input  WIDTH  signed operand b.
- in_c  input  WIDTH  signed operand c (shift amount and divisor).
- in_d  input  WIDTH  signed operand d.
- out_valid  output  1  results valid.
- out_ready  input  1  consumer accepts results.
- out_tmp  output  WIDTH  (a<<c)+b.
- out_q1  output  WIDTH  b/c + b.
- out_q2  output  WIDTH  (a+b+c*d)/tmp + b.
- div0  output  2  bit0: c==0; bit1: tmp==0.

Behaviour:
- Reset (rst_n low, async): state IDLE; out_valid=0; out_tmp/out_q1/out_q2=0; div0=0; counter=0; in_ready forced 0 while rst_n low.
- States: IDLE -> DIV1 -> DIV2 -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, register a, b, c, tmp=(a<<c)+b and sum=a+b+c*d; load divider with b/c; counter=WIDTH-1; go to DIV1.
- DIV1: one quotient bit per cycle. When counter reaches 0, register q1; load divider with sum/tmp; counter=WIDTH-1; go to DIV2.
- DIV2: same iteration. On the final iteration, register all outputs, set out_valid=1, go to DONE.
- Latency: out_valid rises exactly 2*WIDTH clock edges after the accepting edge.
- DONE: outputs held stable and in_ready=0 until out_valid&&out_ready; then out_valid=0 and state IDLE on that edge. A new accept is possible on the next cycle (no bypass).
- in_valid is ignored outside IDLE.
- Shift: left logical by in_c treated as unsigned; amounts >= WIDTH, including negative c, give 0.
- All add/mul wrap modulo 2^WIDTH. c*d keeps the low WIDTH bits.
- Division is signed and truncates toward zero: divide magnitudes, then negate the quotient if the operand signs differ.
- Division overflow: MIN / -1 = MIN (wraps).
- Divide by zero: quotient = all ones (-1), and the corresponding div0 bit is set. Timing is unchanged (still WIDTH cycles).
- Outputs change only on the DIV2->DONE edge or on reset.
- Reset mid-operation aborts with no partial result: out_valid=0; in_ready=1 on the first edge after rst_n rises.

Test Plan (WIDTH=32):
1. a=3, b=5, c=2, d=4 -> out_tmp=17, out_q1=7, out_q2=5, div0=0. out_valid exactly 64 edges after accept.
2. a=1, b=-9, c=2, d=0 -> out_tmp=-5, out_q1=-13 (-9/2 = -4, truncation), out_q2=-8 (-8/-5 = 1).
3. Divide by zero:
   - a=4, b=6, c=0, d=9 -> out_tmp=10, out_q1=5, out_q2=7, div0=2'b01.
   - a=0, b=0, c=1, d=5 -> out_tmp=0, out_q1=0, out_q2=-1, div0=2'b10.
4. Shift/overflow:
   - a=1, b=2, c=40, d=1 -> out_tmp=2, out_q1=2, out_q2=23.
   - a=0, b=-2^31, c=-1, d=0 -> out_q1=0 (MIN/-1 = MIN, plus b wraps).
5. Hold out_ready=0 for 10 cycles after out_valid with in_valid=1 and new operands -> outputs stable, in_ready=0, no capture. Raise out_ready -> one handshake, IDLE next cycle, new set accepted.
6. Drop rst_n mid-DIV1 (cycle 10 after accept) -> out_valid=0, outputs 0 immediately. After release, in_ready=1 and the next operand set computes correctly.
